// File: rtl/sync_display_pkg.sv
// Shared definitions for the hex 7-segment display counter.
// Holds the segment bus width and type, plus the sixteen active-low
// segment patterns indexed by hex digit. Bit order is {g,f,e,d,c,b,a}.
package sync_display_pkg;

  localparam int SEG_W = 7;

  typedef logic [SEG_W-1:0] seg_t;

  // Active-low: a 0 bit lights that segment.
  localparam seg_t SEG_0 = 7'b1000000;
  localparam seg_t SEG_1 = 7'b1111001;
  localparam seg_t SEG_2 = 7'b0100100;
  localparam seg_t SEG_3 = 7'b0110000;
  localparam seg_t SEG_4 = 7'b0011001;
  localparam seg_t SEG_5 = 7'b0010010;
  localparam seg_t SEG_6 = 7'b0000010;
  localparam seg_t SEG_7 = 7'b1111000;
  localparam seg_t SEG_8 = 7'b0000000;
  localparam seg_t SEG_9 = 7'b0010000;
  localparam seg_t SEG_A = 7'b0001000;
  localparam seg_t SEG_B = 7'b0000011;
  localparam seg_t SEG_C = 7'b1000110;
  localparam seg_t SEG_D = 7'b0100001;
  localparam seg_t SEG_E = 7'b0000110;
  localparam seg_t SEG_F = 7'b0001110;

endpackage

// File: rtl/hex_to_7seg.sv
// Combinational hex nibble to 7-segment decoder (active-low cathodes).
// Ports:
//   nibble : input  [3:0] hex value to display
//   seg    : output seg_t active-low segments, seg[0]=a .. seg[6]=g
module hex_to_7seg
  import sync_display_pkg::*;
(
  input  logic [3:0] nibble,
  output seg_t       seg
);

  always_comb begin
    seg = SEG_0;
    case (nibble)
      4'h0: seg = SEG_0;
      4'h1: seg = SEG_1;
      4'h2: seg = SEG_2;
      4'h3: seg = SEG_3;
      4'h4: seg = SEG_4;
      4'h5: seg = SEG_5;
      4'h6: seg = SEG_6;
      4'h7: seg = SEG_7;
      4'h8: seg = SEG_8;
      4'h9: seg = SEG_9;
      4'hA: seg = SEG_A;
      4'hB: seg = SEG_B;
      4'hC: seg = SEG_C;
      4'hD: seg = SEG_D;
      4'hE: seg = SEG_E;
      4'hF: seg = SEG_F;
      default: seg = SEG_0;
    endcase
  end

endmodule

// File: rtl/sync_display_counter.sv
// Free-running hex counter shown on one common-anode 7-segment digit.
// A clock-enable prescaler turns clk into a count tick every TICK_DIV
// cycles; a 4-bit counter steps on each tick and wraps after COUNT_MAX.
// Ports:
//   clk : input  system clock, all state on rising edge
//   btn : input  synchronous active-high reset
//   seg : output active-low segment cathodes, seg[0]=a .. seg[6]=g
//   an  : output active-low digit anode, tied on (0)
module sync_display_counter
  import sync_display_pkg::*;
#(
  parameter int TICK_DIV  = 50_000_000,
  parameter int COUNT_MAX = 15
) (
  input  logic clk,
  input  logic btn,
  output seg_t seg,
  output logic an
);

  // A divide-by-1 prescaler still needs a one-bit register to exist.
  localparam int              PRE_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);
  localparam logic [3:0]       CNT_LAST = 4'(COUNT_MAX);

  logic [PRE_W-1:0] r_pre;
  logic [3:0]       r_cnt;
  logic             w_tick;

  // Tick is asserted during the last prescaler cycle, so the counter
  // steps on the same edge that returns the prescaler to zero.
  assign w_tick = (r_pre == PRE_LAST);

  always_ff @(posedge clk) begin
    if (btn) begin
      r_pre <= '0;
      r_cnt <= '0;
    end else begin
      if (w_tick) begin
        r_pre <= '0;
        r_cnt <= (r_cnt == CNT_LAST) ? 4'd0 : r_cnt + 4'd1;
      end else begin
        r_pre <= r_pre + 1'b1;
      end
    end
  end

  hex_to_7seg u_dec (
    .nibble (r_cnt),
    .seg    (seg)
  );

  assign an = 1'b0;

endmodule

// File: tb/tb_sync_display_counter.sv
// Bench for sync_display_counter: two instances (TICK_DIV=4/COUNT_MAX=15
// and TICK_DIV=1/COUNT_MAX=9) plus a standalone decoder. The driver
// pushes the expected display for each edge; the monitor pops and checks.
module tb_sync_display_counter;
  import sync_display_pkg::*;

  localparam int A_DIV = 4;
  localparam int A_MAX = 15;
  localparam int B_DIV = 1;
  localparam int B_MAX = 9;

  // Reference decode table, bits g..a, active-low.
  localparam logic [6:0] TBL [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  typedef struct packed {
    logic [6:0] seg_a;
    logic [6:0] seg_b;
  } exp_t;

  logic clk = 1'b0;
  logic btn_a = 1'b1;
  logic btn_b = 1'b1;
  seg_t seg_a, seg_b, seg_u;
  logic an_a, an_b;
  logic [3:0] nib = 4'd0;

  int checks = 0;
  int failures = 0;
  int since_a = 0;
  int since_b = 0;
  int txn = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  sync_display_counter #(.TICK_DIV(A_DIV), .COUNT_MAX(A_MAX)) dut_a (
    .clk (clk), .btn (btn_a), .seg (seg_a), .an (an_a)
  );

  sync_display_counter #(.TICK_DIV(B_DIV), .COUNT_MAX(B_MAX)) dut_b (
    .clk (clk), .btn (btn_b), .seg (seg_b), .an (an_b)
  );

  hex_to_7seg u_unit (
    .nibble (nib), .seg (seg_u)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected value depends only on edges elapsed since the last reset edge.
  task automatic drive(input logic ba, input logic bb);
    exp_t e;
    @(negedge clk);
    btn_a = ba;
    btn_b = bb;
    if (ba) since_a = 0; else since_a++;
    if (bb) since_b = 0; else since_b++;
    e.seg_a = TBL[(since_a / A_DIV) % (A_MAX + 1)];
    e.seg_b = TBL[(since_b / B_DIV) % (B_MAX + 1)];
    sb.push_back(e);
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      txn++;
      $display("txn %0d btn_a=%b btn_b=%b seg_a=%b exp_a=%b seg_b=%b exp_b=%b",
               txn, btn_a, btn_b, seg_a, e.seg_a, seg_b, e.seg_b);
      check_eq("seg_a", 32'(seg_a), 32'(e.seg_a));
      check_eq("seg_b", 32'(seg_b), 32'(e.seg_b));
      check_eq("an_a", 32'(an_a), 32'd0);
      check_eq("an_b", 32'(an_b), 32'd0);
    end
  end

  initial begin
    // Decoder unit sweep over all nibbles.
    for (int i = 0; i < 16; i++) begin
      nib = 4'(i);
      #1;
      check_eq($sformatf("dec_%0h", i), 32'(seg_u), 32'(TBL[i]));
    end

    // Reset held for 5 edges.
    for (int i = 0; i < 5; i++) drive(1'b1, 1'b1);

    // Full sweep of A (64 edges back to 0); B wraps 0..9 repeatedly.
    for (int i = 0; i < 64; i++) drive(1'b0, 1'b0);

    // Mid-operation reset on A: count to 5, go 2 edges into the period.
    drive(1'b1, 1'b0);
    for (int i = 0; i < 22; i++) drive(1'b0, 1'b0);
    drive(1'b1, 1'b1);
    for (int i = 0; i < 12; i++) drive(1'b0, 1'b0);

    // Let the monitor drain the scoreboard, bounded.
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    #2;
    check_eq("sb_drain", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
